// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipeline stall/flush sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDiv     = 2'd1,
        StExcWait = 2'd2
    } ctrl_state_e;

    localparam int unsigned NumStages = 5;
    localparam int unsigned StageF    = 0;
    localparam int unsigned StageD    = 1;
    localparam int unsigned StageE    = 2;
    localparam int unsigned StageM    = 3;
    localparam int unsigned StageW    = 4;

    localparam int unsigned DIV_CYCLES_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT      = 6;

    // Mask with the given stages set.
    function automatic logic [NumStages-1:0] stage_mask(input logic f, input logic d,
                                                        input logic e, input logic m,
                                                        input logic w);
        logic [NumStages-1:0] mask;
        mask         = '0;
        mask[StageF] = f;
        mask[StageD] = d;
        mask[StageE] = e;
        mask[StageM] = m;
        mask[StageW] = w;
        return mask;
    endfunction

endpackage

// File: rtl/stall_cnt.sv
// Loadable down-counter with hold, clear and zero flag; never decrements below zero.
module stall_cnt
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Per-stage stall/flush sequencer for F/D/E/M/W: memory waits, load-use, multi-cycle
// divide and M-stage exceptions, resolved by fixed priority each cycle.
module pipe_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_stall_i,
    input  logic data_stall_i,
    input  logic load_use_d_i,
    input  logic div_start_e_i,
    input  logic exc_m_i,
    output logic stall_f_o,
    output logic stall_d_o,
    output logic stall_e_o,
    output logic stall_m_o,
    output logic stall_w_o,
    output logic flush_f_o,
    output logic flush_d_o,
    output logic flush_e_o,
    output logic flush_m_o,
    output logic flush_w_o,
    output logic div_busy_o,
    output logic div_done_o,
    output logic div_abort_o,
    output logic exc_take_o
);

    ctrl_state_e state_q, state_d;

    logic [NumStages-1:0] stall, flush;
    logic                 div_busy, div_done, div_abort, exc_take;
    logic                 cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]     cnt;

    // Issue cycle is the first of DIV_CYCLES, so the counter starts two below.
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 2);

    stall_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .load_i    (cnt_load),
        .load_val_i(DivLoad),
        .dec_i     (cnt_dec),
        .cnt_o     (cnt),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        stall     = '0;
        flush     = '0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        div_abort = 1'b0;
        exc_take  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        if (rst) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else if (exc_m_i || (state_q == StExcWait)) begin
            if (inst_stall_i) begin
                // Redirect cannot proceed until the fetch bus is free.
                stall   = '1;
                state_d = StExcWait;
            end else begin
                // Pending data access is squashed along with the faulting instruction.
                flush     = stage_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
                exc_take  = 1'b1;
                div_abort = (state_q == StDiv);
                state_d   = StIdle;
                cnt_clr   = 1'b1;
            end
        end else if (inst_stall_i || data_stall_i) begin
            stall = '1;
        end else begin
            case (state_q)
                StDiv: begin
                    div_busy = 1'b1;
                    if (cnt_zero) begin
                        div_done = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        stall   = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                        flush   = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                        cnt_dec = 1'b1;
                    end
                end
                StIdle: begin
                    if (div_start_e_i) begin
                        stall    = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                        flush    = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                        div_busy = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = StDiv;
                    end else if (load_use_d_i) begin
                        stall = stage_mask(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                        flush = stage_mask(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_f_o   = stall[StageF];
    assign stall_d_o   = stall[StageD];
    assign stall_e_o   = stall[StageE];
    assign stall_m_o   = stall[StageM];
    assign stall_w_o   = stall[StageW];
    assign flush_f_o   = flush[StageF];
    assign flush_d_o   = flush[StageD];
    assign flush_e_o   = flush[StageE];
    assign flush_m_o   = flush[StageM];
    assign flush_w_o   = flush[StageW];
    assign div_busy_o  = div_busy;
    assign div_done_o  = div_done;
    assign div_abort_o = div_abort;
    assign exc_take_o  = exc_take;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table plus multi-cycle divide/exception/reset sequences.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst;
    logic inst_stall, data_stall, load_use_d, div_start_e, exc_m;
    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_f, flush_d, flush_e, flush_m, flush_w;
    logic div_busy, div_done, div_abort, exc_take;

    pipe_stall_ctrl #(
        .DIV_CYCLES(32),
        .CNT_W     (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_stall_i (inst_stall),
        .data_stall_i (data_stall),
        .load_use_d_i (load_use_d),
        .div_start_e_i(div_start_e),
        .exc_m_i      (exc_m),
        .stall_f_o    (stall_f),
        .stall_d_o    (stall_d),
        .stall_e_o    (stall_e),
        .stall_m_o    (stall_m),
        .stall_w_o    (stall_w),
        .flush_f_o    (flush_f),
        .flush_d_o    (flush_d),
        .flush_e_o    (flush_e),
        .flush_m_o    (flush_m),
        .flush_w_o    (flush_w),
        .div_busy_o   (div_busy),
        .div_done_o   (div_done),
        .div_abort_o  (div_abort),
        .exc_take_o   (exc_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input vector {rst, inst_stall, data_stall, load_use_d, div_start_e, exc_m}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_INST = 6'b010000;
    localparam logic [5:0] I_DATA = 6'b001000;
    localparam logic [5:0] I_LU   = 6'b000100;
    localparam logic [5:0] I_DIV  = 6'b000010;
    localparam logic [5:0] I_EXC  = 6'b000001;

    // Output vector {stall w..f, flush w..f, busy, done, abort, take}
    localparam logic [13:0] O_ZERO  = 14'b00000_00000_0000;
    localparam logic [13:0] O_ALLST = 14'b11111_00000_0000;
    localparam logic [13:0] O_LU    = 14'b00011_00100_0000;
    localparam logic [13:0] O_TAKE  = 14'b00000_01111_0001;
    localparam logic [13:0] O_ABTK  = 14'b00000_01111_0011;
    localparam logic [13:0] O_DIV   = 14'b00111_01000_1000;
    localparam logic [13:0] O_DONE  = 14'b00000_00000_1100;

    localparam int DivCycles = 32;

    typedef struct {
        logic [5:0]  in;
        logic [13:0] exp;
        string       name;
    } vec_t;

    logic [13:0] dout;
    assign dout = {stall_w, stall_m, stall_e, stall_d, stall_f,
                   flush_w, flush_m, flush_e, flush_d, flush_f,
                   div_busy, div_done, div_abort, exc_take};

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Scoreboard: each expectation is retired on the falling edge of the cycle it was driven in.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (dout !== e) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", nm, dout, e);
            end
        end
    end

    task automatic step(input logic [5:0] in, input logic [13:0] exp, input string nm);
        @(posedge clk);
        #1;
        {rst, inst_stall, data_stall, load_use_d, div_start_e, exc_m} = in;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Divide with an optional memory wait of wait_len cycles starting at cycle wait_at.
    task automatic run_div(input string tag, input int wait_at, input int wait_len);
        int c;
        int active;
        c      = 0;
        active = 0;
        while (active < DivCycles - 1) begin
            if (wait_len > 0 && c >= wait_at && c < wait_at + wait_len) begin
                step(I_DIV | I_DATA, O_ALLST, $sformatf("%s_wait_c%0d", tag, c));
            end else begin
                step(I_DIV, O_DIV, $sformatf("%s_run_c%0d", tag, c));
                active++;
            end
            c++;
        end
        step(I_DIV, O_DONE, $sformatf("%s_done_c%0d", tag, c));
        step(I_NONE, O_ZERO, $sformatf("%s_after_done", tag));
        step(I_NONE, O_ZERO, $sformatf("%s_idle", tag));
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{I_RST | I_LU | I_EXC | I_INST, O_ZERO, "reset_masks_all"};
        tbl[1]  = '{I_NONE,                        O_ZERO, "idle"};
        tbl[2]  = '{I_LU,                          O_LU,   "load_use"};
        tbl[3]  = '{I_NONE,                        O_ZERO, "load_use_one_cycle"};
        tbl[4]  = '{I_DATA | I_LU,                 O_ALLST, "data_wait_over_lu"};
        tbl[5]  = '{I_INST,                        O_ALLST, "inst_wait"};
        tbl[6]  = '{I_EXC | I_DATA,                O_TAKE, "exc_ignores_data_wait"};
        tbl[7]  = '{I_NONE,                        O_ZERO, "after_take"};
        tbl[8]  = '{I_EXC | I_INST,                O_ALLST, "exc_behind_fetch"};
        tbl[9]  = '{I_INST,                        O_ALLST, "exc_wait_remembered"};
        tbl[10] = '{I_NONE,                        O_TAKE, "exc_wait_take"};
        tbl[11] = '{I_NONE,                        O_ZERO, "after_wait_take"};
        tbl[12] = '{I_EXC | I_LU | I_DIV,          O_TAKE, "exc_over_lu_div"};
        tbl[13] = '{I_RST,                         O_ZERO, "reset_again"};

        {rst, inst_stall, data_stall, load_use_d, div_start_e, exc_m} = I_RST;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].in, tbl[i].exp, tbl[i].name);
        end

        // Plain divide: stalls on cycles 0..30, done on 31
        run_div("div", 0, 0);

        // Three-cycle data wait from cycle 10 pushes done to cycle 34
        run_div("divwait", 10, 3);

        // Exception behind a busy fetch bus: 4 all-stall cycles then the redirect
        step(I_EXC | I_INST, O_ALLST, "excf_c0");
        for (int c = 1; c < 4; c++) begin
            step(I_INST, O_ALLST, $sformatf("excf_c%0d", c));
        end
        step(I_NONE, O_TAKE, "excf_take");
        step(I_NONE, O_ZERO, "excf_after");

        // Exception at cycle 5 of a divide aborts it; no done pulse afterwards
        for (int c = 0; c < 5; c++) begin
            step(I_DIV, O_DIV, $sformatf("excd_run_c%0d", c));
        end
        step(I_DIV | I_EXC, O_ABTK, "excd_abort");
        for (int c = 6; c < 40; c++) begin
            step(I_NONE, O_ZERO, $sformatf("excd_quiet_c%0d", c));
        end

        // Reset at cycle 7 of a divide, then a fresh full-length divide
        for (int c = 0; c < 7; c++) begin
            step(I_DIV, O_DIV, $sformatf("rstd_run_c%0d", c));
        end
        step(I_RST | I_DIV, O_ZERO, "rstd_reset");
        step(I_NONE, O_ZERO, "rstd_after");
        step(I_NONE, O_ZERO, "rstd_idle");
        run_div("rstd_fresh", 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
